dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The parameter list SHALL be:
- LATENCY, default 2: number of cycles from request acceptance to the first rsp_valid cycle; legal range 1..15.
- DEPTH, default 3072: number of 32-bit storage words.

REQ-002 The ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- req_valid, in, 1: CPU-side request present.
- req_ready, out, 1: responder can accept a request.
- req_we, in, 1: 1 = store, 0 = load.
- req_addr, in, 32: byte address.
- req_be, in, 4: byte enables for stores; bit i selects wdata[8i+7:8i].
- req_wdata, in, 32: store data.
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: CPU accepts the response.
- rsp_rdata, out, 32: load data; 0 for stores and errors.
- rsp_err, out, 1: the accepted request was misaligned or out of range.

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, WAIT and RESP.

REQ-004 req_ready SHALL be 1 only in IDLE; at most one request is outstanding.

REQ-005 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; all request fields are captured at that edge.

REQ-006 An accepted request SHALL be flagged as an error when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH.

REQ-007 A non-error store SHALL update mem[req_addr[13:2]] at the acceptance edge, writing only the bytes whose req_be bit is 1.

REQ-008 A store with req_be=4'b0000 SHALL leave memory unchanged and SHALL NOT be an error.

REQ-009 A non-error load SHALL snapshot mem[req_addr[13:2]] at the acceptance edge; a later store cannot alter a response already in flight.

REQ-010 Errored requests SHALL NOT modify memory, SHALL set rsp_err=1 and SHALL set rsp_rdata=0.

REQ-011 On acceptance, the FSM SHALL go IDLE->RESP when LATENCY=1, and otherwise IDLE->WAIT with a down-counter loaded with LATENCY-1.

REQ-012 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go WAIT->RESP on the edge where the counter equals 1.

REQ-013 rsp_valid SHALL be 1 exactly in RESP, so it first rises LATENCY cycles after the acceptance edge.

REQ-014 In RESP, rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_ready=1; at that edge the FSM goes RESP->IDLE.

REQ-015 After RESP->IDLE, req_ready SHALL be 1 in the following cycle; there is no back-to-back acceptance in the same cycle as response completion.

REQ-016 rsp_ready asserted outside RESP SHALL be ignored.

REQ-017 req_valid deasserted while the block is not in IDLE SHALL have no effect.

REQ-018 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.

REQ-019 The internal counter SHALL be 4 bits wide and SHALL never wrap; it is only loaded in IDLE.

Reset
REQ-020 While reset=1 at a rising edge, the block SHALL:
- enter IDLE;
- clear the counter;
- clear all DEPTH memory words to 0;
- drive req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0 from the following cycle.

REQ-021 When reset and an acceptance coincide, reset SHALL win: no write and no capture occur.

REQ-022 Reset asserted during WAIT or RESP SHALL abort the transaction with no response ever issued. A store accepted before reset was already committed but is then cleared by the memory reset.

Verification
REQ-023 Store then load, LATENCY=2:
- Stimulus: store addr 0x0000_0010, be=4'hF, wdata=0x1234_5678; after its response, load 0x10.
- Required: each rsp_valid rises exactly 2 cycles after acceptance; load returns 0x1234_5678 with rsp_err=0.

REQ-024 Partial byte store:
- Stimulus: on word 0x20 holding 0xAABB_CCDD, store be=4'b0101, wdata=0x1122_3344; then load 0x20.
- Required: load returns 0xAA22_CC44.

REQ-025 Error cases:
- Stimulus: load 0x0000_0013; then store 0x0000_3000, be=4'hF.
- Required: both responses carry rsp_err=1 and rsp_rdata=0; word 0 of memory is unchanged.

REQ-026 Backpressure:
- Stimulus: load, then hold rsp_ready=0 for 5 cycles after rsp_valid rises, with req_valid=1 throughout.
- Required: rsp_valid and rsp_rdata stay stable; req_ready=0 for the whole time; the response completes on the rsp_ready=1 edge; req_ready=1 on the next cycle.

REQ-027 Reset mid-transaction:
- Stimulus: store 0x4 = 0xDEAD_BEEF, assert reset during WAIT, then load 0x4.
- Required: no response is issued for the store; the load returns 0x0000_0000.

REQ-028 LATENCY=1 and simultaneous events:
- Stimulus: issue a request with LATENCY=1; separately, assert reset and req_valid in the same cycle.
- Required: rsp_valid is high on the cycle after acceptance; for the reset cycle, the request is not accepted and memory is untouched.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with a fixed response delay.
// Latency: rsp_valid rises LATENCY cycles after request acceptance (LATENCY=1: the very next cycle).
// Backpressure: the response is held stable until rsp_ready; req_ready is high only while idle.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset (also clears all DEPTH words)
//   req_valid/req_ready request handshake; req_we, req_addr, req_be, req_wdata request fields
//   rsp_valid/rsp_ready response handshake; rsp_rdata load data, rsp_err misaligned/out-of-range
module dm_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_err;
  logic        w_wr_en;
  logic [11:0] w_idx;
  logic [31:0] w_old;
  logic [31:0] w_merged;
  logic [31:0] w_mem [DEPTH];

  // Acceptance only happens in IDLE; reset priority is applied inside each register.
  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_idx    = req_addr[13:2];
  assign w_err    = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign w_wr_en  = w_accept && req_we && !w_err;
  assign w_old    = w_mem[w_idx];

  // Read-modify-write merge: only enabled byte lanes take the new data.
  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < 4; b++) begin
      if (req_be[b]) w_merged[8*b +: 8] = req_wdata[8*b +: 8];
    end
  end

  // One register per word so the whole array can be cleared by reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [31:0] r_word;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_word <= '0;
      end else if (w_wr_en && (w_idx == 12'(g))) begin
        r_word <= w_merged;
      end
    end
    assign w_mem[g] = r_word;
  end

  // State register and delay counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= 4'(LATENCY - 1);
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;  // guarded so it never wraps below zero
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response capture: load data is snapshotted at acceptance, so later stores cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err   <= w_err;
      r_rdata <= (w_err || req_we) ? 32'd0 : w_old;
    end
  end

  // Outputs: response fields are forced to zero outside RESP.
  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rsp_rdata = (r_state == S_RESP) ? r_rdata : 32'd0;
    rsp_err   = (r_state == S_RESP) && r_err;
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized and directed checks of dm_responder against a word-array model.
// Latency: main instance uses LATENCY=2, a second instance uses LATENCY=1.
// Backpressure: response holding is exercised with rsp_ready low for several cycles.
module tb_dm_responder;
  localparam int DEPTH = 3072;

  logic        clk;
  logic        reset;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_we, b_rsp_ready;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_mem [4096];

  dm_responder #(.LATENCY(2), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dm_responder #(.LATENCY(1), .DEPTH(DEPTH)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_be(b_req_be), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit mdl_is_err(input logic [31:0] addr);
    return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] mdl_expect(input bit we, input logic [31:0] addr);
    if (we || mdl_is_err(addr)) return 32'd0;
    return mdl_mem[(addr / 4) % 4096];
  endfunction

  task automatic mdl_store(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w;
    if (mdl_is_err(addr)) return;
    w = mdl_mem[(addr / 4) % 4096];
    for (int i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    mdl_mem[(addr / 4) % 4096] = w;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 4096; i++) mdl_mem[i] = 32'd0;
  endtask

  // ---------------- driver (no checking) ----------------
  // lat = number of falling edges after acceptance until rsp_valid seen (-1 on timeout).
  task automatic drive(input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int hold, input bit keep_valid,
                       output int lat, output logic [31:0] rd, output bit er,
                       output bit stable, output bit rdy_after);
    int n;
    stable = 1'b1; lat = -1; rd = '0; er = 1'b0; rdy_after = 1'b0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    if (!keep_valid) req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    if (!rsp_valid) begin req_valid = 1'b0; return; end
    lat = n; rd = rsp_rdata; er = rsp_err;
    repeat (hold) begin
      if (!(rsp_valid && rsp_rdata === rd && rsp_err === er && !req_ready)) stable = 1'b0;
      @(negedge clk);
    end
    if (!(rsp_valid && rsp_rdata === rd && rsp_err === er && !req_ready)) stable = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    rdy_after = req_ready && !rsp_valid;
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
    reset = 1'b0;
    mdl_clear();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle got rdy=%b vld=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; bit er, st, ra;
    drive(1'b1, 32'h10, 4'hF, 32'h1234_5678, 0, 1'b0, lat, rd, er, st, ra);
    mdl_store(32'h10, 4'hF, 32'h1234_5678);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sl_store_lat got %0d want 2", lat); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL sl_store_rsp got %h/%b want 0/0", rd, er); end
    drive(1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sl_load_lat got %0d want 2", lat); end
    checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL sl_load_rsp got %h/%b want 12345678/0", rd, er); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL sl_ready_after got %b want 1", ra); end
  endtask

  task automatic test_partial();
    int lat; logic [31:0] rd; bit er, st, ra;
    drive(1'b1, 32'h20, 4'hF, 32'hAABB_CCDD, 0, 1'b0, lat, rd, er, st, ra);
    mdl_store(32'h20, 4'hF, 32'hAABB_CCDD);
    drive(1'b1, 32'h20, 4'b0101, 32'h1122_3344, 0, 1'b0, lat, rd, er, st, ra);
    mdl_store(32'h20, 4'b0101, 32'h1122_3344);
    drive(1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL pb_be0_err got %b want 0", er); end
    drive(1'b0, 32'h20, 4'h0, 32'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== 32'hAA22_CC44) begin errors++; $display("FAIL pb_load got %h want aa22cc44", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; bit er, st, ra;
    drive(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 1'b0, lat, rd, er, st, ra);
    mdl_store(32'h0, 4'hF, 32'hCAFE_F00D);
    drive(1'b0, 32'h13, 4'h0, 32'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_misaligned got %h/%b want 0/1", rd, er); end
    drive(1'b1, 32'h3000, 4'hF, 32'h5A5A_5A5A, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_range got %h/%b want 0/1", rd, er); end
    drive(1'b1, 32'h4000, 4'hF, 32'h0BAD_0BAD, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_alias got %b want 1", er); end
    drive(1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== mdl_expect(1'b0, 32'h0) || er !== 1'b0) begin errors++; $display("FAIL err_word0 got %h want %h", rd, mdl_expect(1'b0, 32'h0)); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; bit er, st, ra;
    drive(1'b0, 32'h10, 4'h0, 32'h0, 5, 1'b1, lat, rd, er, st, ra);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_lat got %0d want 2", lat); end
    checks++; if (rd !== mdl_expect(1'b0, 32'h10)) begin errors++; $display("FAIL bp_data got %h want %h", rd, mdl_expect(1'b0, 32'h10)); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", st); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", ra); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; bit er, st, ra;
    bit we; logic [31:0] addr, wd, exp_rd; logic [3:0] be; bit exp_er; int sel, hold;
    for (int t = 0; t < 60; t++) begin
      we   = $urandom_range(0, 1) != 0;
      sel  = $urandom_range(0, 7);
      addr = 32'($urandom_range(0, 15)) * 4;
      if (sel == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (sel == 1) addr = 32'h4000 + addr;
      else if (sel == 2) addr = (DEPTH + 32'($urandom_range(0, 200))) * 4;
      be   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      exp_rd = mdl_expect(we, addr);
      exp_er = mdl_is_err(addr);
      drive(we, addr, be, wd, hold, 1'b0, lat, rd, er, st, ra);
      if (we) mdl_store(addr, be, wd);
      checks++;
      if (lat !== 2 || rd !== exp_rd || er !== exp_er || st !== 1'b1 || ra !== 1'b1) begin
        errors++;
        $display("FAIL rnd_%0d we=%b addr=%h got lat=%0d rd=%h er=%b st=%b ra=%b want lat=2 rd=%h er=%b st=1 ra=1",
                 t, we, addr, lat, rd, er, st, ra, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; bit er, st, ra; bit seen;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h4; req_be = 4'hF; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_clear();
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_rsp got rsp_valid seen=%b want 0", seen); end
    drive(1'b0, 32'h4, 4'h0, 32'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== 32'd0 || lat !== 2) begin errors++; $display("FAIL rm_load got %h lat=%0d want 0 lat=2", rd, lat); end
  endtask

  task automatic test_reset_collide();
    int lat; logic [31:0] rd; bit er, st, ra; bit seen;
    drive(1'b1, 32'h8, 4'hF, 32'h55AA_1234, 0, 1'b0, lat, rd, er, st, ra);
    mdl_store(32'h8, 4'hF, 32'h55AA_1234);
    @(negedge clk);
    reset = 1'b1;
    req_we = 1'b1; req_addr = 32'h8; req_be = 4'hF; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    mdl_clear();
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (rsp_valid || !req_ready) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rc_not_accepted got busy=%b want 0", seen); end
    drive(1'b0, 32'h8, 4'h0, 32'h0, 0, 1'b0, lat, rd, er, st, ra);
    checks++; if (rd !== mdl_expect(1'b0, 32'h8)) begin errors++; $display("FAIL rc_mem got %h want %h", rd, mdl_expect(1'b0, 32'h8)); end
  endtask

  task automatic drive_b(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output bit er);
    int n;
    lat = -1; rd = '0; er = 1'b0;
    @(negedge clk);
    b_req_we = we; b_req_addr = addr; b_req_be = 4'hF; b_req_wdata = wd;
    b_req_valid = 1'b1; b_rsp_ready = 1'b0;
    n = 0;
    while (!b_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_req_ready) begin b_req_valid = 1'b0; return; end
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_rsp_valid && n < 50);
    if (!b_rsp_valid) return;
    lat = n; rd = b_rsp_rdata; er = b_rsp_err;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_latency1();
    int lat; logic [31:0] rd; bit er; logic [31:0] v;
    v = $urandom;
    drive_b(1'b1, 32'h40, v, lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l1_store_lat got %0d want 1", lat); end
    drive_b(1'b0, 32'h40, 32'h0, lat, rd, er);
    checks++; if (lat !== 1 || rd !== v || er !== 1'b0) begin errors++; $display("FAIL l1_load got lat=%0d rd=%h er=%b want 1/%h/0", lat, rd, er, v); end
    @(negedge clk);
    checks++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL l1_idle got rdy=%b vld=%b want 1/0", b_req_ready, b_rsp_valid); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_be = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_partial();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_reset_collide();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
